// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: shared definitions for the APB-to-SRAM bridge.
//   - state_t      : bridge FSM states (IDLE, WR, RD_WAIT, ERR)
//   - RD_LAT_MIN/MAX: supported SRAM read-latency range
//   - CNT_W        : width of the read wait counter (covers RD_LAT_MAX)
//   - PAR_W/mem_w  : SRAM word width; one extra parity bit when
//                    APB_SRAM_PARITY_EN is defined
//   - even_parity  : parity helper used on the write and read paths
package apb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    ERR     = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int CNT_W      = 2;

`ifdef APB_SRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // SRAM word width for a given APB data width
  function automatic int mem_w(input int data_w);
    return data_w + PAR_W;
  endfunction

  // Even parity bit: makes the total count of ones (data + parity) even.
  // Callers zero-extend narrower vectors, which leaves parity unchanged.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/apb_sram_bridge_if.sv
// apb_sram_bridge_if: APB completer-side bus bundle for apb_sram_bridge.
//   PSel/PEnable/PWrite/PAddress/PWData : driven by the APB requester
//   PRData/PReady/PSLERR                : driven by the bridge
// Modports: master (requester view), slave (bridge view).
interface apb_sram_bridge_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              PSel;
  logic              PEnable;
  logic              PWrite;
  logic [ADDR_W-1:0] PAddress;
  logic [DATA_W-1:0] PWData;
  logic [DATA_W-1:0] PRData;
  logic              PReady;
  logic              PSLERR;

  modport master (
    output PSel, PEnable, PWrite, PAddress, PWData,
    input  PRData, PReady, PSLERR
  );

  modport slave (
    input  PSel, PEnable, PWrite, PAddress, PWData,
    output PRData, PReady, PSLERR
  );
endinterface

// File: rtl/apb_sram_bank_decode.sv
// apb_sram_bank_decode: combinational split of an APB word address.
//   paddr        : APB word address
//   bank         : bank index (upper field above the per-bank word bits)
//   word         : word address inside the bank
//   out_of_range : address at or beyond NUM_BANKS << BANK_AW
module apb_sram_bank_decode #(
  parameter int ADDR_W    = 9,
  parameter int NUM_BANKS = 2,
  parameter int BANK_AW   = 8,
  parameter int BANK_W    = 1
) (
  input  logic [ADDR_W-1:0]  paddr,
  output logic [BANK_W-1:0]  bank,
  output logic [BANK_AW-1:0] word,
  output logic               out_of_range
);
  // One extra bit so the limit is representable when it equals 2**ADDR_W
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_BANKS << BANK_AW);

  generate
    if (NUM_BANKS > 1) begin : g_multi
      assign bank = paddr[BANK_AW +: BANK_W];
    end else begin : g_single
      assign bank = {BANK_W{1'b0}};
    end
  endgenerate

  assign word         = paddr[BANK_AW-1:0];
  assign out_of_range = ({1'b0, paddr} >= LIMIT);

endmodule

// File: rtl/apb_sram_bridge.sv
// apb_sram_bridge: APB completer driving NUM_BANKS single-port SRAM banks.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   apb          : APB completer bus (apb_sram_bridge_if.slave)
//   CEn          : active-low per-bank chip enables (registered)
//   WEn          : active-low write enable (registered)
//   A, D         : bank word address / write data (registered, held)
//   Q            : bank read data, bank b at [b*MEM_W +: MEM_W]
// Optional feature macro: APB_SRAM_PARITY_EN adds an even-parity bit on D
// and checks it on reads (mismatch reported as PSLERR).
module apb_sram_bridge
  import apb_sram_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 2,
  parameter int BANK_AW   = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  apb_sram_bridge_if.slave                   apb,
  output logic [NUM_BANKS-1:0]               CEn,
  output logic                               WEn,
  output logic [BANK_AW-1:0]                 A,
  output logic [DATA_W+PAR_W-1:0]            D,
  input  logic [NUM_BANKS*(DATA_W+PAR_W)-1:0] Q
);
  localparam int MEM_W  = mem_w(DATA_W);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("apb_sram_bridge: RD_LAT out of supported range");
    end
  endgenerate

  state_t               state_r, state_s;
  logic [NUM_BANKS-1:0] cen_r, cen_s;
  logic                 wen_r, wen_s;
  logic [BANK_AW-1:0]   a_r, a_s;
  logic [MEM_W-1:0]     d_r, d_s;
  logic [BANK_W-1:0]    bank_r, bank_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 pready_r, pready_s;
  logic                 pslerr_r, pslerr_s;

  logic [BANK_W-1:0]    dec_bank_s;
  logic [BANK_AW-1:0]   dec_word_s;
  logic                 dec_oor_s;
  logic [MEM_W-1:0]     wr_word_s;
  logic [MEM_W-1:0]     q_banks_s [NUM_BANKS];
  logic [MEM_W-1:0]     q_sel_s;
  logic                 rd_ready_s;
  logic                 par_err_s;

  apb_sram_bank_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_BANKS(NUM_BANKS),
    .BANK_AW  (BANK_AW),
    .BANK_W   (BANK_W)
  ) u_decode (
    .paddr       (apb.PAddress),
    .bank        (dec_bank_s),
    .word        (dec_word_s),
    .out_of_range(dec_oor_s)
  );

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_qsplit
      assign q_banks_s[g] = Q[g*MEM_W +: MEM_W];
    end
  endgenerate

  assign q_sel_s = q_banks_s[bank_r];

  // Read data is only valid in the ready cycle of a read, so it is taken
  // straight from the selected bank's Q rather than re-registered.
  assign rd_ready_s = (state_r == RD_WAIT) && pready_r;

`ifdef APB_SRAM_PARITY_EN
  assign wr_word_s = {even_parity(64'(apb.PWData)), apb.PWData};
  assign par_err_s = rd_ready_s && even_parity(64'(q_sel_s));
`else
  assign wr_word_s = apb.PWData;
  assign par_err_s = 1'b0;
`endif

  // Next-state and next-output logic of the transfer FSM
  always_comb begin
    state_s  = state_r;
    cen_s    = {NUM_BANKS{1'b1}};
    wen_s    = 1'b1;
    a_s      = a_r;
    d_s      = d_r;
    bank_s   = bank_r;
    cnt_s    = cnt_r;
    pready_s = 1'b0;
    pslerr_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (apb.PSel && !apb.PEnable) begin
          bank_s = dec_bank_s;
          a_s    = dec_word_s;
          d_s    = wr_word_s;
          if (dec_oor_s) begin
            // No SRAM strobe; respond with an error in the first access cycle
            state_s  = ERR;
            pready_s = 1'b1;
            pslerr_s = 1'b1;
          end else if (apb.PWrite) begin
            state_s           = WR;
            cen_s[dec_bank_s] = 1'b0;
            wen_s             = 1'b0;
            pready_s          = 1'b1;
          end else begin
            state_s           = RD_WAIT;
            cen_s[dec_bank_s] = 1'b0;
            cnt_s             = CNT_W'(RD_LAT);
          end
        end else begin
          state_s = IDLE;
        end
      end

      WR, ERR: begin
        // Single-cycle responses: done (or abandoned) after this cycle
        state_s = IDLE;
      end

      RD_WAIT: begin
        if (!apb.PSel) begin
          // Requester gave up: drop the transfer without a response
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (pready_r) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          // Counter reaches zero in access cycle RD_LAT+1, the ready cycle
          cnt_s    = cnt_r - 2'd1;
          pready_s = (cnt_r == 2'd1);
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cen_r    <= {NUM_BANKS{1'b1}};
      wen_r    <= 1'b1;
      a_r      <= {BANK_AW{1'b0}};
      d_r      <= {MEM_W{1'b0}};
      bank_r   <= {BANK_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      pready_r <= 1'b0;
      pslerr_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cen_r    <= cen_s;
      wen_r    <= wen_s;
      a_r      <= a_s;
      d_r      <= d_s;
      bank_r   <= bank_s;
      cnt_r    <= cnt_s;
      pready_r <= pready_s;
      pslerr_r <= pslerr_s;
    end
  end

  assign CEn        = cen_r;
  assign WEn        = wen_r;
  assign A          = a_r;
  assign D          = d_r;
  assign apb.PReady = pready_r;
  assign apb.PSLERR = pslerr_r | par_err_s;
  assign apb.PRData = rd_ready_s ? q_sel_s[DATA_W-1:0] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_apb_sram_bridge.sv
// tb_apb_sram_bridge: scoreboard bench for apb_sram_bridge.
// dut0: 2 banks, RD_LAT=2. dut1: 1 bank, RD_LAT=1 (out-of-range cases).
// Both share the same APB stimulus; each test checks the relevant one.
module tb_apb_sram_bridge;
  import apb_sram_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MW = DW + PAR_W;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;

  apb_sram_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) apb0 ();
  apb_sram_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) apb1 ();

  assign apb0.PSel = psel;  assign apb0.PEnable = penable; assign apb0.PWrite = pwrite;
  assign apb0.PAddress = paddr; assign apb0.PWData = pwdata;
  assign apb1.PSel = psel;  assign apb1.PEnable = penable; assign apb1.PWrite = pwrite;
  assign apb1.PAddress = paddr; assign apb1.PWData = pwdata;

  logic [1:0]      cen0;
  logic            wen0;
  logic [7:0]      a0;
  logic [MW-1:0]   d0;
  logic [0:0]      cen1;
  logic            wen1;
  logic [7:0]      a1;
  logic [MW-1:0]   d1;
  logic [MW-1:0]   qv0, qv1;
  logic [2*MW-1:0] q0;
  logic [MW-1:0]   q1;
  assign q0 = {qv1, qv0};
  assign q1 = qv0;

  apb_sram_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(2), .BANK_AW(8), .RD_LAT(2)) dut0 (
    .clock(clock), .reset(reset), .apb(apb0),
    .CEn(cen0), .WEn(wen0), .A(a0), .D(d0), .Q(q0));

  apb_sram_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(1), .BANK_AW(8), .RD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .apb(apb1),
    .CEn(cen1), .WEn(wen1), .A(a1), .D(d1), .Q(q1));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  // SRAM word with a consistent parity bit (when parity is built in)
  function automatic logic [MW-1:0] mkq(input logic [DW-1:0] v);
`ifdef APB_SRAM_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  task automatic idle_cycle();
    psel = 1'b0; penable = 1'b0;
    @(posedge clock); #1;
  endtask

  // Full APB transfer; entered and left at posedge+1
  task automatic do_xfer(input bit use1, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input string name);
    exp_t e;
    logic [MW-1:0] qsel;
    logic [1:0] ecen;
    logic rdy, err, oor;
    logic [DW-1:0] rd;
    int cyc;
    bit seen;
    oor  = use1 ? (addr >= 9'h100) : 1'b0;
    qsel = (use1 || addr[8] == 1'b0) ? qv0 : qv1;
    e.err = oor;
`ifdef APB_SRAM_PARITY_EN
    if (!wr && !oor && (^qsel)) e.err = 1'b1;
`endif
    e.rdata = (wr || oor) ? 16'h0000 : qsel[DW-1:0];
    e.lat   = (oor || wr) ? 1 : (use1 ? 2 : 3);
    sb.push_back(e);

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clock); #1;
    penable = 1'b1;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 8) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        if (use1) begin
          total++;
          if (cen1 !== (oor ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL %s cen1: got %b want %b", name, cen1, oor ? 1'b1 : 1'b0);
          end
        end else begin
          ecen = 2'b11; ecen[addr[8]] = 1'b0;
          total++;
          if (cen0 !== ecen || wen0 !== !wr || a0 !== addr[7:0]) begin
            bad++; $display("FAIL %s strobe: got cen=%b wen=%b a=%h want cen=%b wen=%b a=%h",
                            name, cen0, wen0, a0, ecen, !wr, addr[7:0]);
          end
          if (wr) begin
            total++;
            if (d0 !== mkq(wdata)) begin
              bad++; $display("FAIL %s d: got %h want %h", name, d0, mkq(wdata));
            end
          end
        end
      end
      if (cyc == 2 && !use1) begin
        total++;
        if (cen0 !== 2'b11) begin
          bad++; $display("FAIL %s cen_release: got %b want 11", name, cen0);
        end
      end
      rdy = use1 ? apb1.PReady : apb0.PReady;
      rd  = use1 ? apb1.PRData : apb0.PRData;
      err = use1 ? apb1.PSLERR : apb0.PSLERR;
      if (rdy === 1'b1) begin
        seen = 1'b1;
      end else begin
        total++;
        if (rd !== 16'h0000) begin
          bad++; $display("FAIL %s prdata_idle: got %h want 0000", name, rd);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s timeout: got no PReady want PReady", name);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if (cyc !== e.lat || rd !== e.rdata || err !== e.err) begin
        bad++; $display("FAIL %s resp: got cyc=%0d rdata=%h err=%b want cyc=%0d rdata=%h err=%b",
                        name, cyc, rd, err, e.lat, e.rdata, e.err);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 9'h000; pwdata = 16'h0000;
    qv0 = mkq(16'h1234); qv1 = mkq(16'hBEEF);
    @(posedge clock); @(negedge clock);
    total++;
    if (cen0 !== 2'b11 || wen0 !== 1'b1 || a0 !== 8'h00 || d0 !== {MW{1'b0}}) begin
      bad++; $display("FAIL reset_sram: got cen=%b wen=%b a=%h d=%h want 11 1 00 0", cen0, wen0, a0, d0);
    end
    total++;
    if (apb0.PReady !== 1'b0 || apb0.PSLERR !== 1'b0 || apb0.PRData !== 16'h0000) begin
      bad++; $display("FAIL reset_apb: got rdy=%b err=%b rd=%h want 0 0 0000",
                      apb0.PReady, apb0.PSLERR, apb0.PRData);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_write();
    do_xfer(1'b0, 1'b1, 9'h105, 16'hA5A5, "write_105");
    idle_cycle();
    // A and D hold after the transfer; strobes inactive
    @(negedge clock);
    total++;
    if (a0 !== 8'h05 || d0 !== mkq(16'hA5A5) || cen0 !== 2'b11 || wen0 !== 1'b1) begin
      bad++; $display("FAIL write_hold: got a=%h d=%h cen=%b wen=%b want 05 %h 11 1",
                      a0, d0, cen0, wen0, mkq(16'hA5A5));
    end
    @(posedge clock); #1;
  endtask

  task automatic test_read();
    do_xfer(1'b0, 1'b0, 9'h005, 16'h0000, "read_005");
    idle_cycle();
    do_xfer(1'b0, 1'b0, 9'h1AB, 16'h0000, "read_1ab");
    idle_cycle();
  endtask

  task automatic test_out_of_range();
    do_xfer(1'b1, 1'b0, 9'h1FF, 16'h0000, "oor_1ff");
    idle_cycle();
    do_xfer(1'b1, 1'b0, 9'h0FF, 16'h0000, "dut1_rd_0ff");
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b0, 1'b1, 9'h0A0, 16'h5A5A, "b2b_wr");
    do_xfer(1'b0, 1'b0, 9'h1AB, 16'h0000, "b2b_rd");
    do_xfer(1'b0, 1'b1, 9'h1C3, 16'h0F0F, "b2b_wr2");
    idle_cycle();
  endtask

  task automatic test_abort();
    int rdy_seen;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 9'h003;
    @(posedge clock); #1;
    penable = 1'b1;
    @(negedge clock);
    total++;
    if (cen0 !== 2'b10) begin
      bad++; $display("FAIL abort_strobe: got %b want 10", cen0);
    end
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (apb0.PReady !== 1'b0 || cen0 !== 2'b11) rdy_seen++;
    end
    total++;
    if (rdy_seen != 0) begin
      bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", rdy_seen);
    end
    @(posedge clock); #1;
    do_xfer(1'b0, 1'b0, 9'h005, 16'h0000, "after_abort");
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 9'h004;
    @(posedge clock); #1;
    penable = 1'b1;
    @(negedge clock);
    total++;
    if (cen0 !== 2'b10) begin
      bad++; $display("FAIL rstmid_strobe: got %b want 10", cen0);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (cen0 !== 2'b11 || apb0.PReady !== 1'b0 || a0 !== 8'h00 || wen0 !== 1'b1) begin
      bad++; $display("FAIL rstmid_async: got cen=%b rdy=%b a=%h wen=%b want 11 0 00 1",
                      cen0, apb0.PReady, a0, wen0);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    do_xfer(1'b0, 1'b0, 9'h004, 16'h0000, "after_reset");
    idle_cycle();
  endtask

`ifdef APB_SRAM_PARITY_EN
  task automatic test_parity();
    qv0 = 17'h1_0000;
    do_xfer(1'b0, 1'b0, 9'h010, 16'h0000, "parity_bad");
    idle_cycle();
    qv0 = mkq(16'h1234);
    do_xfer(1'b0, 1'b0, 9'h010, 16'h0000, "parity_good");
    idle_cycle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef APB_SRAM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
